// File: rtl/mem_port_arbiter_if.sv
// Shared-memory port bundle: instruction fetch, data access and the single-port memory.
interface mem_port_arbiter_if #(
    parameter int unsigned ADDR_W = 13
);
    logic              if_req;
    logic [31:0]       if_addr;
    logic              if_gnt;
    logic              if_rvalid;
    logic [31:0]       if_rdata;

    logic              d_req;
    logic              d_we;
    logic [1:0]        d_size;
    logic              d_unsigned;
    logic [31:0]       d_addr;
    logic [31:0]       d_wdata;
    logic              d_gnt;
    logic              d_rvalid;
    logic              d_err;
    logic [31:0]       d_rdata;

    logic [ADDR_W-1:0] mem_addr;
    logic [3:0]        mem_be;
    logic              mem_we;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;

    // Arbiter side
    modport slave (
        input  if_req, if_addr,
        output if_gnt, if_rvalid, if_rdata,
        input  d_req, d_we, d_size, d_unsigned, d_addr, d_wdata,
        output d_gnt, d_rvalid, d_err, d_rdata,
        output mem_addr, mem_be, mem_we, mem_wdata,
        input  mem_rdata
    );

    // Requester / memory side
    modport master (
        output if_req, if_addr,
        input  if_gnt, if_rvalid, if_rdata,
        output d_req, d_we, d_size, d_unsigned, d_addr, d_wdata,
        input  d_gnt, d_rvalid, d_err, d_rdata,
        input  mem_addr, mem_be, mem_we, mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbitrates instruction fetch and data accesses onto one synchronous single-port memory,
// with a bounded data streak so fetch cannot starve, and aligns/extends load results.
module mem_port_arbiter #(
    parameter int unsigned ADDR_W       = 13,
    parameter int unsigned MAX_D_STREAK = 3
) (
    input  logic              clk,
    input  logic              reset,
    mem_port_arbiter_if.slave bus
);
    localparam int unsigned STREAK_W = (MAX_D_STREAK < 2) ? 1 : $clog2(MAX_D_STREAK + 1);
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_D_STREAK);
    localparam logic [3:0] BE_NONE = 4'b0000;
    localparam logic [3:0] BE_ALL  = 4'b1111;
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_D    = 2'd2
    } owner_e;

    typedef struct packed {
        owner_e     owner;
        logic [1:0] offset;
        logic [1:0] size;
        logic       uns;
    } trk_t;

    localparam trk_t TRK_IDLE = '{owner: OWN_NONE, offset: 2'b00, size: 2'b00, uns: 1'b0};

    trk_t                trk_q;
    trk_t                trk_d;
    logic [STREAK_W-1:0] streak_q;
    logic [STREAK_W-1:0] streak_d;
    logic                gnt_if;
    logic                gnt_d;
    logic                misalign;
    logic                if_rvalid_c;
    logic                d_rvalid_c;
    logic [31:0]         shifted;
    logic                unused_addr_bits;

    // Only the word index of each address reaches memory.
    assign unused_addr_bits = ^{bus.if_addr, bus.d_addr};

    always_ff @(posedge clk) begin
        if (reset) begin
            trk_q    <= TRK_IDLE;
            streak_q <= '0;
        end else begin
            trk_q    <= trk_d;
            streak_q <= streak_d;
        end
    end

    assign misalign = ((bus.d_size == SZ_HALF) && bus.d_addr[0]) ||
                      (bus.d_size[1] && (bus.d_addr[1:0] != 2'b00));

    // Grant selection, memory command and next tracker/streak state.
    always_comb begin
        gnt_if        = 1'b0;
        gnt_d         = 1'b0;
        trk_d         = TRK_IDLE;
        streak_d      = streak_q;
        bus.mem_addr  = '0;
        bus.mem_be    = BE_NONE;
        bus.mem_we    = 1'b0;
        bus.mem_wdata = '0;
        bus.d_err     = 1'b0;

        if (!reset) begin
            if (bus.if_req && (!bus.d_req || (streak_q == STREAK_MAX))) begin
                gnt_if = 1'b1;
            end else if (bus.d_req) begin
                gnt_d = 1'b1;
            end
        end

        if (gnt_if) begin
            bus.mem_addr = bus.if_addr[ADDR_W+1:2];
            bus.mem_be   = BE_ALL;
            trk_d.owner  = OWN_IF;
        end else if (gnt_d) begin
            bus.mem_addr = bus.d_addr[ADDR_W+1:2];
            if (misalign) begin
                bus.d_err = 1'b1;
            end else if (bus.d_we) begin
                bus.mem_we = 1'b1;
                unique case (bus.d_size)
                    SZ_BYTE: begin
                        bus.mem_be    = 4'b0001 << bus.d_addr[1:0];
                        bus.mem_wdata = {4{bus.d_wdata[7:0]}};
                    end
                    SZ_HALF: begin
                        bus.mem_be    = 4'b0011 << bus.d_addr[1:0];
                        bus.mem_wdata = {2{bus.d_wdata[15:0]}};
                    end
                    default: begin
                        bus.mem_be    = BE_ALL;
                        bus.mem_wdata = bus.d_wdata;
                    end
                endcase
            end else begin
                bus.mem_be = BE_ALL;
                trk_d      = '{owner: OWN_D, offset: bus.d_addr[1:0],
                               size: bus.d_size, uns: bus.d_unsigned};
            end
        end

        if (gnt_if || !bus.if_req) begin
            streak_d = '0;
        end else if (gnt_d && (streak_q != STREAK_MAX)) begin
            streak_d = streak_q + STREAK_W'(1);
        end
    end

    assign bus.if_gnt = gnt_if;
    assign bus.d_gnt  = gnt_d;

    // Response path: reset masks a response still owed by a grant from the previous cycle.
    always_comb begin
        if_rvalid_c = !reset && (trk_q.owner == OWN_IF);
        d_rvalid_c  = !reset && (trk_q.owner == OWN_D);
        shifted     = bus.mem_rdata >> {trk_q.offset, 3'b000};

        bus.if_rvalid = if_rvalid_c;
        bus.if_rdata  = if_rvalid_c ? bus.mem_rdata : 32'h0;
        bus.d_rvalid  = d_rvalid_c;
        bus.d_rdata   = 32'h0;

        if (d_rvalid_c) begin
            unique case (trk_q.size)
                SZ_BYTE: bus.d_rdata = trk_q.uns ? {24'h0, shifted[7:0]}
                                                 : {{24{shifted[7]}}, shifted[7:0]};
                SZ_HALF: bus.d_rdata = trk_q.uns ? {16'h0, shifted[15:0]}
                                                 : {{16{shifted[15]}}, shifted[15:0]};
                default: bus.d_rdata = shifted;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus random traffic,
// with load/fetch responses scoreboarded against a shadow memory.
module tb_mem_port_arbiter;
    localparam int unsigned ADDR_W       = 13;
    localparam int unsigned MAX_D_STREAK = 3;

    logic clk = 1'b0;
    logic reset;
    logic load_mem;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_err = 0;
    int   streak_m = 0;

    typedef struct {
        int          due;
        logic [31:0] data;
    } resp_t;

    resp_t       q_if[$];
    resp_t       q_d[$];
    resp_t       r;
    logic [31:0] mem    [256];
    logic [31:0] shadow [256];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mem_port_arbiter_if #(.ADDR_W(ADDR_W)) bus ();

    mem_port_arbiter #(.ADDR_W(ADDR_W), .MAX_D_STREAK(MAX_D_STREAK)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Synchronous memory, 1-cycle read latency
    always @(posedge clk) begin
        if (load_mem) begin
            for (int i = 0; i < 256; i++) mem[i] <= shadow[i];
        end else if (bus.mem_we) begin
            for (int b = 0; b < 4; b++)
                if (bus.mem_be[b]) mem[bus.mem_addr[7:0]][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
        end
        bus.mem_rdata <= mem[bus.mem_addr[7:0]];
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [31:0] ld_model(logic [31:0] w, logic [1:0] off, logic [1:0] sz, logic uns);
        logic [31:0] sh;
        sh = w >> (8 * off);
        case (sz)
            2'b00:   return uns ? {24'h0, sh[7:0]} : {{24{sh[7]}}, sh[7:0]};
            2'b01:   return uns ? {16'h0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
            default: return sh;
        endcase
    endfunction

    // Response monitor
    always @(negedge clk) begin
        if (reset) begin
            check_val("rst_if_rvalid", 32'(bus.if_rvalid), 32'h0);
            check_val("rst_d_rvalid", 32'(bus.d_rvalid), 32'h0);
        end else begin
            if (bus.if_rvalid) begin
                if (q_if.size() == 0) begin
                    check_val("if_rvalid_unexpected", 32'(bus.if_rvalid), 32'h0);
                end else begin
                    r = q_if.pop_front();
                    check_val("if_resp_cycle", 32'(cyc), 32'(r.due));
                    check_val("if_rdata", bus.if_rdata, r.data);
                end
            end else begin
                check_val("if_rdata_idle", bus.if_rdata, 32'h0);
                if (q_if.size() != 0 && q_if[0].due <= cyc) begin
                    check_val("if_rvalid_missing", 32'(bus.if_rvalid), 32'h1);
                    void'(q_if.pop_front());
                end
            end
            if (bus.d_rvalid) begin
                if (q_d.size() == 0) begin
                    check_val("d_rvalid_unexpected", 32'(bus.d_rvalid), 32'h0);
                end else begin
                    r = q_d.pop_front();
                    check_val("d_resp_cycle", 32'(cyc), 32'(r.due));
                    check_val("d_rdata", bus.d_rdata, r.data);
                end
            end else begin
                check_val("d_rdata_idle", bus.d_rdata, 32'h0);
                if (q_d.size() != 0 && q_d[0].due <= cyc) begin
                    check_val("d_rvalid_missing", 32'(bus.d_rvalid), 32'h1);
                    void'(q_d.pop_front());
                end
            end
        end
    end

    // Apply one cycle of requests and check the combinational grant/memory command.
    task automatic drive(input logic ir, input logic [31:0] ia, input logic dr, input logic dwe,
                         input logic [1:0] dsz, input logic duns, input logic [31:0] da,
                         input logic [31:0] dwd);
        logic        exp_if, exp_d, mis;
        logic [3:0]  ebe;
        logic        ewe;
        logic [31:0] ewd;
        int          idx;
        bus.if_req = ir;  bus.if_addr = ia;
        bus.d_req  = dr;  bus.d_we = dwe; bus.d_size = dsz;
        bus.d_unsigned = duns; bus.d_addr = da; bus.d_wdata = dwd;
        #1;
        exp_if = ir && (!dr || streak_m == int'(MAX_D_STREAK));
        exp_d  = dr && !exp_if;
        mis    = ((dsz == 2'b01) && da[0]) || (dsz[1] && (da[1:0] != 2'b00));
        ebe = 4'b0000; ewe = 1'b0; ewd = 32'h0;
        if (exp_if) ebe = 4'b1111;
        else if (exp_d && !mis && !dwe) ebe = 4'b1111;
        else if (exp_d && !mis && dwe) begin
            ewe = 1'b1;
            case (dsz)
                2'b00:   begin ebe = 4'b0001 << da[1:0]; ewd = {4{dwd[7:0]}}; end
                2'b01:   begin ebe = 4'b0011 << da[1:0]; ewd = {2{dwd[15:0]}}; end
                default: begin ebe = 4'b1111; ewd = dwd; end
            endcase
        end
        check_val("if_gnt", 32'(bus.if_gnt), 32'(exp_if));
        check_val("d_gnt", 32'(bus.d_gnt), 32'(exp_d));
        check_val("d_err", 32'(bus.d_err), 32'(exp_d && mis));
        check_val("mem_be", 32'(bus.mem_be), 32'(ebe));
        check_val("mem_we", 32'(bus.mem_we), 32'(ewe));
        if (exp_if) begin
            check_val("mem_addr_if", 32'(bus.mem_addr), 32'(ia[14:2]));
            q_if.push_back('{due: cyc + 1, data: shadow[ia[9:2]]});
        end
        if (exp_d) begin
            check_val("mem_addr_d", 32'(bus.mem_addr), 32'(da[14:2]));
            idx = int'(da[9:2]);
            if (!mis && dwe) begin
                check_val("mem_wdata", bus.mem_wdata, ewd);
                for (int b = 0; b < 4; b++)
                    if (ebe[b]) shadow[idx][8*b +: 8] = ewd[8*b +: 8];
            end else if (!mis) begin
                q_d.push_back('{due: cyc + 1, data: ld_model(shadow[idx], da[1:0], dsz, duns)});
            end
        end
        if (exp_if || !ir) streak_m = 0;
        else if (exp_d && streak_m != int'(MAX_D_STREAK)) streak_m++;
    endtask

    task automatic idle();
        drive(1'b0, 32'h0, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [4:0] pat5;
        logic [3:0] pat4;
        reset = 1'b1; load_mem = 1'b1;
        for (int i = 0; i < 256; i++) shadow[i] = $urandom;
        shadow[4]  = 32'h0050_0093;
        shadow[16] = 32'h8001_FFFF;
        bus.if_req = 1'b1; bus.if_addr = 32'h10;
        bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_size = 2'b10; bus.d_unsigned = 1'b0;
        bus.d_addr = 32'h40; bus.d_wdata = 32'hFFFF_FFFF;

        // Requests asserted during reset must produce nothing
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_if_gnt", 32'(bus.if_gnt), 32'h0);
        check_val("rst_d_gnt", 32'(bus.d_gnt), 32'h0);
        check_val("rst_mem_be", 32'(bus.mem_be), 32'h0);
        check_val("rst_mem_we", 32'(bus.mem_we), 32'h0);
        check_val("rst_d_err", 32'(bus.d_err), 32'h0);
        check_val("rst_if_rdata", bus.if_rdata, 32'h0);
        check_val("rst_d_rdata", bus.d_rdata, 32'h0);
        reset = 1'b0; load_mem = 1'b0; streak_m = 0;
        idle(); adv();

        // Fetch only
        drive(1'b1, 32'h10, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
        check_val("fetch_mem_addr", 32'(bus.mem_addr), 32'h4);
        adv(); idle();
        check_val("fetch_rvalid", 32'(bus.if_rvalid), 32'h1);
        check_val("fetch_rdata", bus.if_rdata, 32'h0050_0093);
        adv();

        // Store byte
        drive(1'b0, 32'h0, 1'b1, 1'b1, 2'b00, 1'b0, 32'h22, 32'hAB);
        check_val("sb_be", 32'(bus.mem_be), 32'h4);
        check_val("sb_wdata", bus.mem_wdata, 32'hABAB_ABAB);
        check_val("sb_we", 32'(bus.mem_we), 32'h1);
        adv(); idle();
        check_val("sb_no_rvalid", 32'(bus.d_rvalid), 32'h0);
        adv();

        // Back-to-back half loads, signed then unsigned
        drive(1'b0, 32'h0, 1'b1, 1'b0, 2'b01, 1'b0, 32'h42, 32'h0);
        adv();
        drive(1'b0, 32'h0, 1'b1, 1'b0, 2'b01, 1'b1, 32'h42, 32'h0);
        check_val("lh_rvalid", 32'(bus.d_rvalid), 32'h1);
        check_val("lh_rdata", bus.d_rdata, 32'hFFFF_8001);
        adv(); idle();
        check_val("lhu_rdata", bus.d_rdata, 32'h0000_8001);
        adv();

        // Misaligned word
        drive(1'b0, 32'h0, 1'b1, 1'b0, 2'b10, 1'b0, 32'h13, 32'h0);
        check_val("mis_gnt", 32'(bus.d_gnt), 32'h1);
        check_val("mis_err", 32'(bus.d_err), 32'h1);
        check_val("mis_be", 32'(bus.mem_be), 32'h0);
        adv(); idle();
        check_val("mis_no_rvalid", 32'(bus.d_rvalid), 32'h0);
        adv();

        // Contention: D,D,D,IF,D
        pat5 = 5'b01000;
        for (int k = 0; k < 5; k++) begin
            drive(1'b1, 32'h100 + 32'(4 * k), 1'b1, 1'b0, 2'b10, 1'b0, 32'h200 + 32'(4 * k), 32'h0);
            check_val("contend_if", 32'(bus.if_gnt), 32'(pat5[k]));
            check_val("contend_d", 32'(bus.d_gnt), 32'(!pat5[k]));
            adv();
        end
        idle(); adv();

        // Reset one cycle after a load grant, with a partial streak built up
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 32'h20, 1'b1, 1'b0, 2'b10, 1'b0, 32'h40 + 32'(4 * k), 32'h0);
            adv();
        end
        reset = 1'b1;
        q_d.delete(); q_if.delete(); streak_m = 0;
        #1;
        check_val("rst_mid_d_rvalid", 32'(bus.d_rvalid), 32'h0);
        check_val("rst_mid_d_rdata", bus.d_rdata, 32'h0);
        check_val("rst_mid_gnt", 32'({bus.if_gnt, bus.d_gnt}), 32'h0);
        adv();
        reset = 1'b0;
        pat4 = 4'b1000;
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 32'h30, 1'b1, 1'b0, 2'b10, 1'b0, 32'h60, 32'h0);
            check_val("post_rst_if", 32'(bus.if_gnt), 32'(pat4[k]));
            adv();
        end
        idle(); adv();

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom_range(0, 1)), 32'($urandom_range(0, 1023)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                  32'($urandom_range(0, 1023)), $urandom);
            adv();
        end
        idle(); adv();
        idle(); adv();
        check_val("if_queue_drained", 32'(q_if.size()), 32'h0);
        check_val("d_queue_drained", 32'(q_d.size()), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
